// File: rtl/video_timing_gen_if.sv
// Purpose: renderer/pin bundle for video_timing_gen (coordinates out, colour in, aligned sync/DE/colour out).
// Latency: none, wires only.
// Backpressure: none; the raster free-runs while ENABLE is high.
// Optional FRAME_COUNT member appears when VIDEO_TIMING_GEN_FRAME_COUNT_EN is defined.
interface video_timing_gen_if #(
    parameter int COLOR_WIDTH = 8,
    parameter int X_WIDTH     = 11,
    parameter int Y_WIDTH     = 10
);
    logic                   ENABLE;
    logic [COLOR_WIDTH-1:0] COLOR_IN;
    logic [X_WIDTH-1:0]     X_PIXEL;
    logic [Y_WIDTH-1:0]     Y_PIXEL;
    logic                   LINE_START;
    logic                   FRAME_START;
    logic [COLOR_WIDTH-1:0] COLOR_OUT;
    logic                   DE;
    logic                   HSYNC;
    logic                   VSYNC;
`ifdef VIDEO_TIMING_GEN_FRAME_COUNT_EN
    logic [15:0]            FRAME_COUNT;

    modport master (
        input  ENABLE, COLOR_IN,
        output X_PIXEL, Y_PIXEL, LINE_START, FRAME_START,
        output COLOR_OUT, DE, HSYNC, VSYNC, FRAME_COUNT
    );
    modport slave (
        output ENABLE, COLOR_IN,
        input  X_PIXEL, Y_PIXEL, LINE_START, FRAME_START,
        input  COLOR_OUT, DE, HSYNC, VSYNC, FRAME_COUNT
    );
`else
    modport master (
        input  ENABLE, COLOR_IN,
        output X_PIXEL, Y_PIXEL, LINE_START, FRAME_START,
        output COLOR_OUT, DE, HSYNC, VSYNC
    );
    modport slave (
        output ENABLE, COLOR_IN,
        input  X_PIXEL, Y_PIXEL, LINE_START, FRAME_START,
        input  COLOR_OUT, DE, HSYNC, VSYNC
    );
`endif
endinterface

// File: rtl/video_timing_gen.sv
// Purpose: parametrised raster timing generator; issues X/Y to a renderer and emits aligned colour, DE, HSYNC, VSYNC.
// Latency: DE/HSYNC/VSYNC/COLOR_OUT follow the issued X/Y by PIXEL_LATENCY+1 cycles; LINE_START/FRAME_START are combinational.
// Backpressure: none; ENABLE low holds the raster at (0,0) and blanks the outputs once the delay line drains.
// Optional per-frame counter (FRAME_COUNT) is built when VIDEO_TIMING_GEN_FRAME_COUNT_EN is defined.
module video_timing_gen #(
    parameter int H_VISIBLE     = 800,
    parameter int H_FRONT       = 40,
    parameter int H_SYNC        = 128,
    parameter int H_BACK        = 88,
    parameter int V_VISIBLE     = 600,
    parameter int V_FRONT       = 1,
    parameter int V_SYNC        = 4,
    parameter int V_BACK        = 23,
    parameter int HSYNC_POL     = 1,
    parameter int VSYNC_POL     = 1,
    parameter int COLOR_WIDTH   = 8,
    parameter int PIXEL_LATENCY = 0,
    parameter int X_WIDTH       = 11,
    parameter int Y_WIDTH       = 10
) (
    input  logic               CLK,
    input  logic               RESET_N,
    video_timing_gen_if.master bus
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [X_WIDTH-1:0] X_LAST   = X_WIDTH'(H_TOTAL - 1);
    localparam logic [X_WIDTH-1:0] X_VIS    = X_WIDTH'(H_VISIBLE);
    localparam logic [X_WIDTH-1:0] X_HS_ON  = X_WIDTH'(H_VISIBLE + H_FRONT);
    localparam logic [X_WIDTH-1:0] X_HS_OFF = X_WIDTH'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [Y_WIDTH-1:0] Y_LAST   = Y_WIDTH'(V_TOTAL - 1);
    localparam logic [Y_WIDTH-1:0] Y_VIS    = Y_WIDTH'(V_VISIBLE);
    localparam logic [Y_WIDTH-1:0] Y_VS_ON  = Y_WIDTH'(V_VISIBLE + V_FRONT);
    localparam logic [Y_WIDTH-1:0] Y_VS_OFF = Y_WIDTH'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic HS_ACT = 1'(HSYNC_POL);
    localparam logic VS_ACT = 1'(VSYNC_POL);

    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } flags_t;

    logic [X_WIDTH-1:0]     x;
    logic [Y_WIDTH-1:0]     y;
    logic                   line_end;
    logic                   frame_end;
    flags_t                 raw;
    flags_t                 delayed;
    logic [COLOR_WIDTH-1:0] color_q;
    logic                   de_q;
    logic                   hsync_q;
    logic                   vsync_q;

    assign line_end  = bus.ENABLE && (x == X_LAST);
    assign frame_end = line_end && (y == Y_LAST);

    // Raw per-pixel flags; gated by ENABLE so a disabled raster feeds blank into the delay line
    always_comb begin
        raw        = '0;
        raw.active = bus.ENABLE && (x < X_VIS) && (y < Y_VIS);
        raw.hs     = bus.ENABLE && (x >= X_HS_ON) && (x < X_HS_OFF);
        raw.vs     = bus.ENABLE && (y >= Y_VS_ON) && (y < Y_VS_OFF);
    end

    // Raster counters: X every pixel, Y on X wrap, both held at zero while disabled
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            x <= '0;
            y <= '0;
        end else if (!bus.ENABLE) begin
            x <= '0;
            y <= '0;
        end else if (line_end) begin
            x <= '0;
            y <= frame_end ? '0 : y + Y_WIDTH'(1);
        end else begin
            x <= x + X_WIDTH'(1);
        end
    end

    generate
        if (PIXEL_LATENCY == 0) begin : g_no_delay
            assign delayed = raw;
        end else begin : g_delay
            flags_t pipe [PIXEL_LATENCY];

            // Carry the flags alongside the renderer's colour pipeline
            always_ff @(posedge CLK or negedge RESET_N) begin
                if (!RESET_N) begin
                    for (int i = 0; i < PIXEL_LATENCY; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= raw;
                    for (int i = 1; i < PIXEL_LATENCY; i++) pipe[i] <= pipe[i-1];
                end
            end

            assign delayed = pipe[PIXEL_LATENCY-1];
        end
    endgenerate

    // Output register: colour gated by the aligned active flag, syncs mapped to their polarity
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            color_q <= '0;
            de_q    <= 1'b0;
            hsync_q <= ~HS_ACT;
            vsync_q <= ~VS_ACT;
        end else begin
            color_q <= delayed.active ? bus.COLOR_IN : '0;
            de_q    <= delayed.active;
            hsync_q <= delayed.hs ? HS_ACT : ~HS_ACT;
            vsync_q <= delayed.vs ? VS_ACT : ~VS_ACT;
        end
    end

    assign bus.X_PIXEL     = x;
    assign bus.Y_PIXEL     = y;
    assign bus.LINE_START  = line_end;
    assign bus.FRAME_START = frame_end;
    assign bus.COLOR_OUT   = color_q;
    assign bus.DE          = de_q;
    assign bus.HSYNC       = hsync_q;
    assign bus.VSYNC       = vsync_q;

`ifdef VIDEO_TIMING_GEN_FRAME_COUNT_EN
    logic [15:0] frame_cnt;

    // Frame counter; FRAME_START is gated by ENABLE so the count holds while disabled
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            frame_cnt <= '0;
        end else if (frame_end) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign bus.FRAME_COUNT = frame_cnt;
`endif
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three instances (SVGA defaults, small raster with latency 2,
// small raster with negative syncs and latency 1) against a position-indexed raster model
// and an expected-output queue per instance, plus directed scenario checks.
module tb_video_timing_gen;
    localparam int ND = 3;
    localparam int HVIS [ND] = '{800, 8, 8};
    localparam int HFP  [ND] = '{40, 2, 2};
    localparam int HSW  [ND] = '{128, 3, 3};
    localparam int HBP  [ND] = '{88, 3, 3};
    localparam int VVIS [ND] = '{600, 4, 4};
    localparam int VFP  [ND] = '{1, 1, 1};
    localparam int VSW  [ND] = '{4, 1, 1};
    localparam int VBP  [ND] = '{23, 2, 2};
    localparam int LAT  [ND] = '{0, 2, 1};
    localparam int HP   [ND] = '{1, 1, 0};
    localparam int VP   [ND] = '{1, 1, 0};

    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic [7:0] col;
    } exp_t;

    logic CLK   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b1;
    always #5 CLK = ~CLK;

    logic [10:0] xo [ND];
    logic [9:0]  yo [ND];
    logic        ls [ND];
    logic        fs [ND];
    logic        de [ND];
    logic        hs [ND];
    logic        vs [ND];
    logic [7:0]  co [ND];
    logic [7:0]  ci [ND];
`ifdef VIDEO_TIMING_GEN_FRAME_COUNT_EN
    logic [15:0] fcnt [ND];
`endif

    int n_cmp = 0;
    int n_bad = 0;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        video_timing_gen_if #(.COLOR_WIDTH(8), .X_WIDTH(11), .Y_WIDTH(10)) vif ();

        video_timing_gen #(
            .H_VISIBLE(HVIS[g]), .H_FRONT(HFP[g]), .H_SYNC(HSW[g]), .H_BACK(HBP[g]),
            .V_VISIBLE(VVIS[g]), .V_FRONT(VFP[g]), .V_SYNC(VSW[g]), .V_BACK(VBP[g]),
            .HSYNC_POL(HP[g]), .VSYNC_POL(VP[g]), .COLOR_WIDTH(8),
            .PIXEL_LATENCY(LAT[g]), .X_WIDTH(11), .Y_WIDTH(10)
        ) dut (
            .CLK    (CLK),
            .RESET_N(rst_n),
            .bus    (vif)
        );

        assign vif.ENABLE   = en;
        assign vif.COLOR_IN = ci[g];
        assign xo[g] = vif.X_PIXEL;
        assign yo[g] = vif.Y_PIXEL;
        assign ls[g] = vif.LINE_START;
        assign fs[g] = vif.FRAME_START;
        assign de[g] = vif.DE;
        assign hs[g] = vif.HSYNC;
        assign vs[g] = vif.VSYNC;
        assign co[g] = vif.COLOR_OUT;
`ifdef VIDEO_TIMING_GEN_FRAME_COUNT_EN
        assign fcnt[g] = vif.FRAME_COUNT;
`endif
    end

    function automatic int ht(int d);
        return HVIS[d] + HFP[d] + HSW[d] + HBP[d];
    endfunction

    function automatic int vt(int d);
        return VVIS[d] + VFP[d] + VSW[d] + VBP[d];
    endfunction

    // Renderer colour for raster position p
    function automatic logic [7:0] color_fn(int d, int p);
        int x;
        int y;
        x = p % ht(d);
        y = p / ht(d);
        if (d == 0) return 8'((x ^ y) & 255);
        if (d == 1) return 8'(x & 255);
        return 8'hFF;
    endfunction

    // ---------------- scoreboard ----------------
    exp_t exp_q [ND][$];
    int   hist  [ND][$];
    int   pos   [ND];
    int   fc_model [ND];
    logic r_prev = 1'b0;
    logic e_prev = 1'b0;
    int   sx, sy;
    logic sls, sfs;
    exp_t sexp, snew;

    // Raster model and expected-output queues, evaluated mid-cycle
    always @(negedge CLK) begin
        for (int d = 0; d < ND; d++) begin
            if (!rst_n) begin
                pos[d] = 0;
                fc_model[d] = 0;
                exp_q[d].delete();
                hist[d].delete();
                for (int i = 0; i <= LAT[d]; i++) exp_q[d].push_back('0);
                sexp = '0;
            end else begin
                if (!r_prev || !e_prev) pos[d] = 0;
                else pos[d] = (pos[d] + 1) % (ht(d) * vt(d));
                sexp = exp_q[d].pop_front();
            end
            sx  = pos[d] % ht(d);
            sy  = pos[d] / ht(d);
            sls = en && (sx == ht(d) - 1);
            sfs = sls && (sy == vt(d) - 1);

            n_cmp++;
            if (xo[d] !== 11'(sx) || yo[d] !== 10'(sy)) begin
                n_bad++;
                $display("FAIL sb_xy dut%0d t=%0t: got (%0d,%0d) want (%0d,%0d)", d, $time, xo[d], yo[d], sx, sy);
            end
            n_cmp++;
            if (ls[d] !== sls || fs[d] !== sfs) begin
                n_bad++;
                $display("FAIL sb_starts dut%0d t=%0t: got ls=%b fs=%b want ls=%b fs=%b", d, $time, ls[d], fs[d], sls, sfs);
            end
            n_cmp++;
            if (de[d] !== sexp.de || co[d] !== sexp.col) begin
                n_bad++;
                $display("FAIL sb_pixel dut%0d t=%0t: got de=%b col=%h want de=%b col=%h", d, $time, de[d], co[d], sexp.de, sexp.col);
            end
            n_cmp++;
            if (hs[d] !== (sexp.hs ^ (HP[d] == 0)) || vs[d] !== (sexp.vs ^ (VP[d] == 0))) begin
                n_bad++;
                $display("FAIL sb_sync dut%0d t=%0t: got hs=%b vs=%b want hs=%b vs=%b", d, $time, hs[d], vs[d],
                         sexp.hs ^ (HP[d] == 0), sexp.vs ^ (VP[d] == 0));
            end
`ifdef VIDEO_TIMING_GEN_FRAME_COUNT_EN
            n_cmp++;
            if (fcnt[d] !== 16'(fc_model[d])) begin
                n_bad++;
                $display("FAIL sb_frame_count dut%0d: got %0d want %0d", d, fcnt[d], fc_model[d]);
            end
            if (rst_n && sfs) fc_model[d] = (fc_model[d] + 1) & 16'hFFFF;
`endif
            if (rst_n) begin
                snew.de  = en && (sx < HVIS[d]) && (sy < VVIS[d]);
                snew.hs  = en && (sx >= HVIS[d] + HFP[d]) && (sx < HVIS[d] + HFP[d] + HSW[d]);
                snew.vs  = en && (sy >= VVIS[d] + VFP[d]) && (sy < VVIS[d] + VFP[d] + VSW[d]);
                snew.col = snew.de ? color_fn(d, pos[d]) : 8'h00;
                exp_q[d].push_back(snew);
                hist[d].push_back(pos[d]);
                while (hist[d].size() > LAT[d] + 1) void'(hist[d].pop_front());
                ci[d] = (hist[d].size() == LAT[d] + 1) ? color_fn(d, hist[d][0]) : 8'h00;
            end else begin
                ci[d] = 8'h00;
            end
        end
        r_prev = rst_n;
        e_prev = en;
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        for (int d = 0; d < ND; d++) begin
            n_cmp++;
            if (de[d] !== 1'b0 || co[d] !== 8'h00 || xo[d] !== 11'd0) begin
                n_bad++;
                $display("FAIL reset_blank dut%0d: got de=%b col=%h x=%0d want 0/00/0", d, de[d], co[d], xo[d]);
            end
            n_cmp++;
            if (hs[d] !== (HP[d] == 0) || vs[d] !== (VP[d] == 0)) begin
                n_bad++;
                $display("FAIL reset_sync dut%0d: got hs=%b vs=%b want hs=%b vs=%b", d, hs[d], vs[d], HP[d] == 0, VP[d] == 0);
            end
        end
        @(posedge CLK);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_raster();
        int hs_cnt = 0;
        int hs_first = -1;
        int i;
        for (int k = 0; k <= 1060; k++) begin
            @(negedge CLK);
            if (k >= 1 && k <= 1056 && hs[0] === 1'b1) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = k;
            end
            if (k < 3) begin
                n_cmp++;
                if (de[1] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL small_de_early k=%0d: got %b want 0", k, de[1]);
                end
            end
            if (k >= 3 && k < 19) begin
                i = k - 3;
                n_cmp++;
                if (de[1] !== (i < 8) || co[1] !== ((i < 8) ? 8'(i) : 8'h00)) begin
                    n_bad++;
                    $display("FAIL small_pixel i=%0d: got de=%b col=%0d want de=%b col=%0d", i, de[1], co[1], i < 8, (i < 8) ? i : 0);
                end
                n_cmp++;
                if (hs[1] !== (i >= 10 && i < 13)) begin
                    n_bad++;
                    $display("FAIL small_hsync i=%0d: got %b want %b", i, hs[1], i >= 10 && i < 13);
                end
            end
            if (k == 127) begin
                n_cmp++;
                if (fs[1] !== 1'b1 || xo[1] !== 11'd15 || yo[1] !== 10'd7) begin
                    n_bad++;
                    $display("FAIL small_frame_end: got fs=%b (%0d,%0d) want 1 (15,7)", fs[1], xo[1], yo[1]);
                end
            end
            if (k == 128) begin
                n_cmp++;
                if (xo[1] !== 11'd0 || yo[1] !== 10'd0) begin
                    n_bad++;
                    $display("FAIL small_frame_wrap: got (%0d,%0d) want (0,0)", xo[1], yo[1]);
                end
            end
            if (k == 1054 || k == 1055) begin
                n_cmp++;
                if (ls[0] !== (k == 1055) || xo[0] !== 11'(k) || yo[0] !== 10'd0) begin
                    n_bad++;
                    $display("FAIL svga_line_end k=%0d: got ls=%b x=%0d y=%0d want ls=%b x=%0d y=0", k, ls[0], xo[0], yo[0], k == 1055, k);
                end
            end
            if (k == 1056) begin
                n_cmp++;
                if (xo[0] !== 11'd0 || yo[0] !== 10'd1 || ls[0] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL svga_line_wrap: got (%0d,%0d) ls=%b want (0,1) ls=0", xo[0], yo[0], ls[0]);
                end
            end
        end
        n_cmp++;
        if (hs_cnt != 128 || hs_first != 841) begin
            n_bad++;
            $display("FAIL svga_hsync_window: got %0d cycles from k=%0d want 128 from k=841", hs_cnt, hs_first);
        end
    endtask

    task automatic test_polarity();
        int hs_lo = 0;
        int vs_lo = 0;
        int de_ff = 0;
        int stray = 0;
        for (int k = 0; k < 128; k++) begin
            @(negedge CLK);
            if (hs[2] === 1'b0) hs_lo++;
            if (vs[2] === 1'b0) vs_lo++;
            if (de[2] === 1'b1 && co[2] === 8'hFF) de_ff++;
            if (de[2] !== 1'b1 && co[2] !== 8'h00) stray++;
        end
        n_cmp++;
        if (hs_lo != 24 || vs_lo != 16) begin
            n_bad++;
            $display("FAIL neg_sync_counts: got hs_lo=%0d vs_lo=%0d want 24/16", hs_lo, vs_lo);
        end
        n_cmp++;
        if (de_ff != 32 || stray != 0) begin
            n_bad++;
            $display("FAIL neg_color_blank: got active_ff=%0d blank_nonzero=%0d want 32/0", de_ff, stray);
        end
    endtask

    task automatic test_enable_gap();
        bit found = 1'b0;
        for (int c = 0; c < 3000 && !found; c++) begin
            @(negedge CLK);
            if (xo[0] == 11'd500) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL gap_wait_timeout: got no X=500 want X=500 within 3000 cycles");
        end
        @(posedge CLK);
        #1 en = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge CLK);
            for (int d = 0; d < ND; d++) begin
                if (j >= 1) begin
                    n_cmp++;
                    if (xo[d] !== 11'd0 || yo[d] !== 10'd0 || ls[d] !== 1'b0) begin
                        n_bad++;
                        $display("FAIL gap_hold dut%0d j=%0d: got (%0d,%0d) ls=%b want (0,0) ls=0", d, j, xo[d], yo[d], ls[d]);
                    end
                end
                if (j >= LAT[d] + 1) begin
                    n_cmp++;
                    if (de[d] !== 1'b0) begin
                        n_bad++;
                        $display("FAIL gap_blank dut%0d j=%0d: got de=%b want 0", d, j, de[d]);
                    end
                end
            end
        end
        @(posedge CLK);
        #1 en = 1'b1;
        for (int j = 0; j < 2; j++) begin
            @(negedge CLK);
            n_cmp++;
            if (xo[0] !== 11'(j) || yo[0] !== 10'd0) begin
                n_bad++;
                $display("FAIL gap_restart j=%0d: got (%0d,%0d) want (%0d,0)", j, xo[0], yo[0], j);
            end
        end
    endtask

    task automatic test_async_reset();
        bit found = 1'b0;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(negedge CLK);
            if (xo[0] == 11'd400) found = 1'b1;
        end
        n_cmp++;
        if (!found || de[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL areset_setup: got found=%0d de=%b want X=400 with de=1", found, de[0]);
        end
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (xo[0] !== 11'd0 || yo[0] !== 10'd0 || de[0] !== 1'b0 || co[0] !== 8'h00 || hs[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL areset_immediate: got (%0d,%0d) de=%b col=%h hs=%b want (0,0) 0 00 0", xo[0], yo[0], de[0], co[0], hs[0]);
        end
        n_cmp++;
        if (hs[2] !== 1'b1 || vs[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL areset_neg_sync: got hs=%b vs=%b want 1/1", hs[2], vs[2]);
        end
        repeat (2) @(posedge CLK);
        #1 rst_n = 1'b1;
        for (int j = 0; j < 2; j++) begin
            @(negedge CLK);
            n_cmp++;
            if (xo[0] !== 11'(j) || yo[0] !== 10'd0) begin
                n_bad++;
                $display("FAIL areset_restart j=%0d: got (%0d,%0d) want (%0d,0)", j, xo[0], yo[0], j);
            end
        end
`ifdef VIDEO_TIMING_GEN_FRAME_COUNT_EN
        repeat (128) @(negedge CLK);
        n_cmp++;
        if (fcnt[1] !== 16'd1 || fcnt[0] !== 16'd0) begin
            n_bad++;
            $display("FAIL frame_count_first: got small=%0d svga=%0d want 1/0", fcnt[1], fcnt[0]);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_raster();
        test_polarity();
        test_enable_gap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator: successor to the fixed 800x600 @ 60 Hz SVGA interface.
- All horizontal/vertical intervals, sync polarities and colour width are parameters.
- Adds a configurable colour-fetch latency: sync, blanking and data-enable are delayed to stay pixel-aligned with COLOR_IN returned by a pipelined renderer.
- Sits between the pixel renderer (consumes X_PIXEL/Y_PIXEL, returns COLOR_IN) and the DAC/pin outputs.

Parameters:
- H_VISIBLE, 800, visible pixels per line
- H_FRONT, 40, horizontal front porch, pixels
- H_SYNC, 128, hsync pulse width, pixels
- H_BACK, 88, horizontal back porch, pixels
- V_VISIBLE, 600, visible lines per frame
- V_FRONT, 1, vertical front porch, lines
- V_SYNC, 4, vsync pulse width, lines
- V_BACK, 23, vertical back porch, lines
- HSYNC_POL, 1, active level of HSYNC (1 = positive)
- VSYNC_POL, 1, active level of VSYNC
- COLOR_WIDTH, 8, colour bus width (opaque value)
- PIXEL_LATENCY, 0, cycles from X/Y presented until matching COLOR_IN valid (0..15)
- X_WIDTH, 11, X counter width; must hold H_TOTAL-1
- Y_WIDTH, 10, Y counter width; must hold V_TOTAL-1

Ports:
- CLK  in  1  pixel clock
- RESET_N  in  1  asynchronous active-low reset
- ENABLE  in  1  run raster; low = hold at (0,0), blank
- COLOR_IN  in  COLOR_WIDTH  renderer colour for coordinates issued PIXEL_LATENCY cycles earlier
- X_PIXEL  out  X_WIDTH  current column, 0 = left edge of visible area
- Y_PIXEL  out  Y_WIDTH  current line, 0 = top edge of visible area
- LINE_START  out  1  pulse, last pixel of each line
- FRAME_START  out  1  pulse, last pixel of each frame
- COLOR_OUT  out  COLOR_WIDTH  aligned colour, 0 when blanked
- DE  out  1  data enable, aligned with COLOR_OUT
- HSYNC  out  1  horizontal sync, aligned
- VSYNC  out  1  vertical sync, aligned

Behaviour:
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise. Ordering per line/frame: visible, front porch, sync, back porch.
- X counts 0..H_TOTAL-1 every cycle while ENABLE=1, then wraps to 0.
- Y increments on X wrap; counts 0..V_TOTAL-1, then wraps to 0.
- LINE_START is combinational: ENABLE && X==H_TOTAL-1.
- FRAME_START is combinational: LINE_START && Y==V_TOTAL-1.
- Per-cycle raw flags from the current X/Y:
  - active = X<H_VISIBLE && Y<V_VISIBLE
  - hs = H_VISIBLE+H_FRONT <= X < H_VISIBLE+H_FRONT+H_SYNC
  - vs = V_VISIBLE+V_FRONT <= Y < V_VISIBLE+V_FRONT+V_SYNC
- Raw flags pass through a PIXEL_LATENCY-deep delay line, then one output register. Total latency from X/Y to DE/HSYNC/VSYNC/COLOR_OUT is PIXEL_LATENCY+1 cycles.
- COLOR_OUT <= delayed_active ? COLOR_IN : 0. DE <= delayed_active.
- HSYNC <= hs_d ? HSYNC_POL : ~HSYNC_POL. VSYNC uses vs_d and VSYNC_POL the same way.
- PIXEL_LATENCY=0 with default parameters gives cycle-identical behaviour to the existing SVGA interface.
- Reset (RESET_N low, asynchronous):
  - X=0, Y=0.
  - Delay line cleared to inactive.
  - COLOR_OUT=0, DE=0, HSYNC=~HSYNC_POL, VSYNC=~VSYNC_POL.
  - Reset release mid-line restarts at (0,0); no partial sync pulse is emitted.
- ENABLE=0:
  - X, Y synchronously cleared to 0 and held.
  - LINE_START/FRAME_START forced 0.
  - Inactive flags shift into the delay line; outputs fully blank/inactive PIXEL_LATENCY+1 cycles after ENABLE falls.
  - On ENABLE rising, first issued coordinate is (0,0).
- Simultaneous wrap: at X=H_TOTAL-1, Y=V_TOTAL-1 both wrap to 0 on the same edge.

Optional Feature:
- Macro: VIDEO_TIMING_GEN_FRAME_COUNT_EN.
- Defined:
  - Adds output FRAME_COUNT [15:0], reset 0, incremented on each cycle FRAME_START=1, wraps 65535->0.
  - Held (not cleared) while ENABLE=0.
- Undefined: port and counter absent; all other behaviour unchanged.

Test Plan:
- Defaults, PIXEL_LATENCY=0, release reset: X steps 0,1,2... At X=1055 LINE_START=1; next cycle X=0, Y=1. At (1055,627) FRAME_START=1; next cycle (0,0). 1056*628 = 663168 cycles per frame.
- Defaults, Y=0: HSYNC=1 from the cycle after X=840 through the cycle after X=967 (128 cycles). VSYNC=1 for exactly 4 lines, starting the cycle after (0,601).
- Small params H=8/2/3/3, V=4/1/1/2, PIXEL_LATENCY=2, COLOR_IN = X delayed 2 cycles:
  - DE rises 3 cycles after (0,0).
  - COLOR_OUT sequence 0..7, then 0 for 8 cycles.
  - HSYNC aligned: high 3 cycles, starting 3 cycles after X=10.
- HSYNC_POL=0, VSYNC_POL=0:
  - After reset, HSYNC=VSYNC=1.
  - During sync windows they read 0.
  - COLOR_OUT=0 for X>=H_VISIBLE or Y>=V_VISIBLE regardless of COLOR_IN=0xFF.
- Assert RESET_N low at (400,300) between clock edges: outputs go to reset values immediately without a clock. After release, X counts from 0 at Y=0.
- ENABLE low for 20 cycles mid-line:
  - X/Y=0 during the low period.
  - DE=0 after PIXEL_LATENCY+1 cycles.
  - ENABLE high restarts at (0,0).
  - With the macro defined, FRAME_COUNT increments to 1 after the first full frame.
